// File: rtl/cpu_pkg.sv
// Shared types for the CPU writeback stage.
// Default sizes come from the NUM_REGS / REG_WIDTH macros when the build does not supply them.
`ifndef NUM_REGS
`define NUM_REGS 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

package cpu_pkg;
    localparam int RW = $clog2(`NUM_REGS);

    typedef struct packed {
        logic                  valid;
        logic [RW-1:0]         dest;
        logic [`REG_WIDTH-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/CPU_bank_reg_if.sv
// Register bank write interface: one ALU write port and one multiplier write port.
interface CPU_bank_reg_if #(
    parameter int NUM_REGS  = `NUM_REGS,
    parameter int REG_WIDTH = `REG_WIDTH
);
    localparam int RW = $clog2(NUM_REGS);

    logic                 write_enable;
    logic [RW-1:0]        write_reg;
    logic [REG_WIDTH-1:0] write_data;
    logic                 write_enable_mul;
    logic [RW-1:0]        write_reg_mul;
    logic [REG_WIDTH-1:0] write_data_mul;

    modport master_write (
        output write_enable, write_reg, write_data,
        output write_enable_mul, write_reg_mul, write_data_mul
    );

    modport slave_write (
        input write_enable, write_reg, write_data,
        input write_enable_mul, write_reg_mul, write_data_mul
    );
endinterface

// File: rtl/cpu_wb_scoreboard.sv
// Pending-result scoreboard: one bit per register, set on multiply issue, cleared on multiply writeback.
module cpu_wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int  NUM_REGS = `NUM_REGS,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                set_valid,
    input  logic [RW-1:0]       set_reg,
    input  logic                clr_valid,
    input  logic [RW-1:0]       clr_reg,
    input  logic [RW-1:0]       rd_reg_a,
    input  logic [RW-1:0]       rd_reg_b,
    input  logic [RW-1:0]       rd_reg_c,
    output logic                rd_a,
    output logic                rd_b,
    output logic                rd_c,
    output logic [NUM_REGS-1:0] pending
);
    logic [NUM_REGS-1:0] pending_q;

    // A new issue to a register beats a completing writeback to the same register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_valid && set_reg == RW'(i)) begin
                    pending_q[i] <= 1'b1;
                end else if (clr_valid && clr_reg == RW'(i)) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    assign rd_a    = pending_q[rd_reg_a];
    assign rd_b    = pending_q[rd_reg_b];
    assign rd_c    = pending_q[rd_reg_c];
    assign pending = pending_q;
endmodule

// File: rtl/cpu_writeback_stage.sv
// Writeback stage: registers ALU and multiplier results into the bank and stalls decode on hazards.
// Define CPU_WB_BYPASS_EN to forward a completing multiply result to decode instead of stalling.
module cpu_writeback_stage
    import cpu_pkg::*;
#(
    parameter int  NUM_REGS  = `NUM_REGS,
    parameter int  REG_WIDTH = `REG_WIDTH,
    localparam int RW        = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alu_valid,
    input  logic [RW-1:0]        alu_reg,
    input  logic [REG_WIDTH-1:0] alu_data,
    input  logic                 mul_issue_valid,
    input  logic [RW-1:0]        mul_issue_reg,
    input  logic                 mul_done_valid,
    input  logic [RW-1:0]        mul_done_reg,
    input  logic [REG_WIDTH-1:0] mul_done_data,
    input  logic                 chk_valid,
    input  logic [RW-1:0]        chk_reg_a,
    input  logic [RW-1:0]        chk_reg_b,
    input  logic [RW-1:0]        chk_dest,
    CPU_bank_reg_if.master_write bank,
    output logic                 stall,
    output logic [NUM_REGS-1:0]  pending
`ifdef CPU_WB_BYPASS_EN
    ,
    output logic                 fwd_a_valid,
    output logic                 fwd_b_valid,
    output logic [REG_WIDTH-1:0] fwd_data
`endif
);
    wb_req_t alu_q;
    wb_req_t mul_q;
    logic    mul_we_q;
    logic    mul_accept;
    logic    wb_conflict;
    logic    pend_a;
    logic    pend_b;
    logic    pend_dest;

    // A multiply result for a register with no outstanding issue (e.g. flushed by reset) is dropped.
    assign mul_accept  = mul_done_valid && pending[mul_done_reg];
    assign wb_conflict = alu_valid && mul_accept && (alu_reg == mul_done_reg);

    // On a same-register collision the ALU result is younger, so only the bank write is suppressed;
    // mul_q.valid still retires the scoreboard entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_q    <= '0;
            mul_q    <= '0;
            mul_we_q <= 1'b0;
        end else begin
            alu_q.valid <= alu_valid;
            if (alu_valid) begin
                alu_q.dest <= alu_reg;
                alu_q.data <= alu_data;
            end
            mul_q.valid <= mul_accept;
            if (mul_accept) begin
                mul_q.dest <= mul_done_reg;
                mul_q.data <= mul_done_data;
            end
            mul_we_q <= mul_accept && !wb_conflict;
        end
    end

    cpu_wb_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_valid (mul_issue_valid),
        .set_reg   (mul_issue_reg),
        .clr_valid (mul_q.valid),
        .clr_reg   (mul_q.dest),
        .rd_reg_a  (chk_reg_a),
        .rd_reg_b  (chk_reg_b),
        .rd_reg_c  (chk_dest),
        .rd_a      (pend_a),
        .rd_b      (pend_b),
        .rd_c      (pend_dest),
        .pending   (pending)
    );

    assign bank.write_enable     = alu_q.valid;
    assign bank.write_reg        = alu_q.dest;
    assign bank.write_data       = alu_q.data;
    assign bank.write_enable_mul = mul_we_q;
    assign bank.write_reg_mul    = mul_q.dest;
    assign bank.write_data_mul   = mul_q.data;

`ifdef CPU_WB_BYPASS_EN
    logic byp_a;
    logic byp_b;
    logic byp_dest;

    assign byp_a       = mul_accept && (mul_done_reg == chk_reg_a);
    assign byp_b       = mul_accept && (mul_done_reg == chk_reg_b);
    assign byp_dest    = mul_accept && (mul_done_reg == chk_dest);
    assign stall       = chk_valid && ((pend_a && !byp_a) || (pend_b && !byp_b) ||
                                       (pend_dest && !byp_dest));
    assign fwd_a_valid = chk_valid && byp_a;
    assign fwd_b_valid = chk_valid && byp_b;
    assign fwd_data    = mul_done_data;
`else
    assign stall = chk_valid && (pend_a || pend_b || pend_dest);
`endif
endmodule

// File: tb/tb_cpu_writeback_stage.sv
// Scoreboard testbench for cpu_writeback_stage: expected bank writes are queued at issue and
// popped by a monitor whenever the DUT presents a write.
module tb_cpu_writeback_stage;
    import cpu_pkg::*;

    localparam int NR = `NUM_REGS;
    localparam int W  = `REG_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          alu_valid;
    logic [RW-1:0] alu_reg;
    logic [W-1:0]  alu_data;
    logic          mul_issue_valid;
    logic [RW-1:0] mul_issue_reg;
    logic          mul_done_valid;
    logic [RW-1:0] mul_done_reg;
    logic [W-1:0]  mul_done_data;
    logic          chk_valid;
    logic [RW-1:0] chk_reg_a;
    logic [RW-1:0] chk_reg_b;
    logic [RW-1:0] chk_dest;
    logic          stall;
    logic [NR-1:0] pending;
`ifdef CPU_WB_BYPASS_EN
    logic          fwd_a_valid;
    logic          fwd_b_valid;
    logic [W-1:0]  fwd_data;
`endif

    CPU_bank_reg_if bank_if ();

    cpu_writeback_stage dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .alu_valid       (alu_valid),
        .alu_reg         (alu_reg),
        .alu_data        (alu_data),
        .mul_issue_valid (mul_issue_valid),
        .mul_issue_reg   (mul_issue_reg),
        .mul_done_valid  (mul_done_valid),
        .mul_done_reg    (mul_done_reg),
        .mul_done_data   (mul_done_data),
        .chk_valid       (chk_valid),
        .chk_reg_a       (chk_reg_a),
        .chk_reg_b       (chk_reg_b),
        .chk_dest        (chk_dest),
        .bank            (bank_if),
        .stall           (stall),
        .pending         (pending)
`ifdef CPU_WB_BYPASS_EN
        ,
        .fwd_a_valid     (fwd_a_valid),
        .fwd_b_valid     (fwd_b_valid),
        .fwd_data        (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      fails  = 0;
    wb_req_t alu_exp[$];
    wb_req_t mul_exp[$];

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        alu_valid       = 1'b0;
        alu_reg         = '0;
        alu_data        = '0;
        mul_issue_valid = 1'b0;
        mul_issue_reg   = '0;
        mul_done_valid  = 1'b0;
        mul_done_reg    = '0;
        mul_done_data   = '0;
        chk_valid       = 1'b0;
        chk_reg_a       = '0;
        chk_reg_b       = '0;
        chk_dest        = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic drive_alu(input int r, input logic [W-1:0] d);
        wb_req_t e;
        alu_valid = 1'b1;
        alu_reg   = RW'(r);
        alu_data  = d;
        e.valid = 1'b1;
        e.dest  = RW'(r);
        e.data  = d;
        alu_exp.push_back(e);
    endtask

    task automatic drive_mul_done(input int r, input logic [W-1:0] d, input bit expect_write);
        wb_req_t e;
        mul_done_valid = 1'b1;
        mul_done_reg   = RW'(r);
        mul_done_data  = d;
        e.valid = 1'b1;
        e.dest  = RW'(r);
        e.data  = d;
        if (expect_write) mul_exp.push_back(e);
    endtask

    task automatic drive_issue(input int r);
        mul_issue_valid = 1'b1;
        mul_issue_reg   = RW'(r);
    endtask

    task automatic drive_chk(input int a, input int b, input int dst);
        chk_valid = 1'b1;
        chk_reg_a = RW'(a);
        chk_reg_b = RW'(b);
        chk_dest  = RW'(dst);
    endtask

    // Monitor: every bank write must match the oldest expected entry for its port.
    always @(negedge clk) begin : monitor
        wb_req_t e;
        if (reset_n === 1'b1) begin
            if (bank_if.write_enable === 1'b1) begin
                if (alu_exp.size() == 0) begin
                    check_output("alu_unexpected_write", 1, 0);
                end else begin
                    e = alu_exp.pop_front();
                    check_output("alu_write_reg", 64'(bank_if.write_reg), 64'(e.dest));
                    check_output("alu_write_data", 64'(bank_if.write_data), 64'(e.data));
                end
            end
            if (bank_if.write_enable_mul === 1'b1) begin
                if (mul_exp.size() == 0) begin
                    check_output("mul_unexpected_write", 1, 0);
                end else begin
                    e = mul_exp.pop_front();
                    check_output("mul_write_reg", 64'(bank_if.write_reg_mul), 64'(e.dest));
                    check_output("mul_write_data", 64'(bank_if.write_data_mul), 64'(e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        idle_inputs();
        reset_n = 1'b0;
        drive_chk(0, 0, 0);
        #2;
        check_output("reset_pending", 64'(pending), 0);
        check_output("reset_stall", 64'(stall), 0);
        check_output("reset_we", 64'(bank_if.write_enable), 0);
        check_output("reset_we_mul", 64'(bank_if.write_enable_mul), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU results are visible exactly one cycle after they are presented.
        next_cycle(); drive_alu(5, 'hAA);
        next_cycle(); drive_alu(1, 'h1234);
        next_cycle(); drive_alu(6, 'hDEADBEEF);
        next_cycle();
        next_cycle(); #1;
        check_output("alu_single_cycle_we", 64'(bank_if.write_enable), 0);

        // RAW hazard on operand a held until the multiply retires.
        next_cycle(); drive_issue(3); #1;
        check_output("pend3_before_edge", 64'(pending[3]), 0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            drive_chk(3, 0, 1);
            if (c == 4) drive_mul_done(3, 'h11112222, 1'b1);
            #1;
            check_output("raw_pend3", 64'(pending[3]), 1);
`ifdef CPU_WB_BYPASS_EN
            check_output("raw_stall", 64'(stall), (c == 4) ? 0 : 1);
`else
            check_output("raw_stall", 64'(stall), 1);
`endif
        end
        next_cycle(); #1;
        check_output("pend3_cycle5", 64'(pending[3]), 1);
        check_output("mul_we_cycle5", 64'(bank_if.write_enable_mul), 1);
        next_cycle(); drive_chk(3, 0, 0); #1;
        check_output("pend3_cycle6", 64'(pending[3]), 0);
        check_output("stall_cycle6", 64'(stall), 0);

        // Same-register collision: ALU wins, multiply bank write suppressed, pending still cleared.
        next_cycle(); drive_issue(7);
        next_cycle(); drive_chk(0, 0, 7); #1;
        check_output("waw_stall", 64'(stall), 1);
        check_output("pend7_set", 64'(pending[7]), 1);
        next_cycle(); drive_alu(7, 'hA7); drive_mul_done(7, 'h77, 1'b0);
        next_cycle(); #1;
        check_output("conflict_we", 64'(bank_if.write_enable), 1);
        check_output("conflict_we_mul", 64'(bank_if.write_enable_mul), 0);
        next_cycle(); #1;
        check_output("conflict_pend7_clear", 64'(pending[7]), 0);

        // Set beats clear when a new issue coincides with the retiring write.
        next_cycle(); drive_issue(2);
        next_cycle(); drive_chk(2, 0, 0); chk_valid = 1'b0; drive_mul_done(2, 'h22, 1'b1); #1;
        check_output("no_chk_no_stall", 64'(stall), 0);
        next_cycle(); drive_issue(2); #1;
        check_output("mul_we_reg2", 64'(bank_if.write_enable_mul), 1);
        next_cycle(); drive_chk(0, 2, 0); #1;
        check_output("set_wins_pend2", 64'(pending[2]), 1);
        check_output("rawb_stall", 64'(stall), 1);
        drive_mul_done(2, 'h2222, 1'b1);
        next_cycle();
        next_cycle(); #1;
        check_output("pend2_cleared", 64'(pending[2]), 0);

        // Completion for a register with nothing pending is ignored.
        next_cycle(); drive_mul_done(6, 'h66, 1'b0);
        next_cycle(); #1;
        check_output("ignored_done_we", 64'(bank_if.write_enable_mul), 0);
        check_output("ignored_done_pend", 64'(pending), 0);

        // Reset mid-multiply discards the in-flight result.
        next_cycle(); drive_issue(4); drive_alu(1, 'h5A);
        next_cycle(); drive_chk(4, 0, 0); #1;
        check_output("pre_reset_stall", 64'(stall), 1);
        #1 reset_n = 1'b0;
        #1;
        check_output("in_reset_pending", 64'(pending), 0);
        check_output("in_reset_stall", 64'(stall), 0);
        check_output("in_reset_we", 64'(bank_if.write_enable), 0);
        check_output("in_reset_wreg", 64'(bank_if.write_reg), 0);
        check_output("in_reset_wdata", 64'(bank_if.write_data), 0);
        next_cycle(); reset_n = 1'b1; drive_mul_done(4, 'h44, 1'b0);
        next_cycle(); #1;
        check_output("post_reset_done_we", 64'(bank_if.write_enable_mul), 0);
        check_output("post_reset_pending", 64'(pending), 0);

        // Completing multiply feeding operand b of the instruction in decode.
        next_cycle(); drive_issue(3);
        next_cycle(); drive_chk(0, 3, 1); drive_mul_done(3, 'h55, 1'b1); #1;
`ifdef CPU_WB_BYPASS_EN
        check_output("bypass_stall", 64'(stall), 0);
        check_output("bypass_fwd_b", 64'(fwd_b_valid), 1);
        check_output("bypass_fwd_a", 64'(fwd_a_valid), 0);
        check_output("bypass_fwd_data", 64'(fwd_data), 'h55);
`else
        check_output("nobypass_stall", 64'(stall), 1);
`endif
        next_cycle();
        next_cycle(); #1;
        check_output("final_pend3", 64'(pending[3]), 0);

        check_output("alu_queue_drained", 64'(alu_exp.size()), 0);
        check_output("mul_queue_drained", 64'(mul_exp.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
